// File: rtl/nibble_pkg.sv
// Shared types and widths for the nibble datapath.
package nibble_pkg;
    localparam int unsigned NIBBLE_W = 4;
    typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one combinational read port.
module fifo_mem #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/nibble_fifo.sv
// First-word-fall-through FIFO for registered nibbles with valid/ready on both sides.
module nibble_fifo
    import nibble_pkg::*;
#(
    parameter int unsigned WIDTH = NIBBLE_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem_rdata;
    logic             push;
    logic             pop;
    logic             unused_wrap;

    // Handshake decodes from registered count only.
    assign wr_ready = (count != PW'(DEPTH));
    assign rd_valid = (count != PW'(0));
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? mem_rdata : '0;

    // Wrap bits only make pointer traces readable; occupancy comes from count.
    assign unused_wrap = wr_ptr[AW] ^ rd_ptr[AW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + PW'(1);
                    2'b01:   count <= count - PW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push && !flush),
        .waddr(wr_ptr[AW-1:0]),
        .wdata(wr_data),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(mem_rdata)
    );
endmodule

// File: tb/tb_nibble_fifo.sv
// Directed bench for nibble_fifo with a queue scoreboard and a reference occupancy model.
module tb_nibble_fifo;
    import nibble_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       wr_valid;
    logic       wr_ready;
    nibble_t    wr_data;
    logic       rd_valid;
    logic       rd_ready;
    nibble_t    rd_data;
    logic [3:0] count;
    logic       overflow;

    int compared = 0;
    int mismatched = 0;

    nibble_t sb_q[$];
    logic    m_ovf;

    nibble_fifo #(.WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data (wr_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data (rd_data),
        .count   (count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare DUT against the model, then advance the model and the clock by one edge.
    task automatic tick(input string tag);
        int  m_count;
        bit  do_push;
        bit  do_pop;
        m_count = sb_q.size();
        chk({tag, ":count"}, 8'(count), 8'(m_count));
        chk({tag, ":rd_valid"}, 8'(rd_valid), 8'(m_count != 0));
        chk({tag, ":wr_ready"}, 8'(wr_ready), 8'(m_count != DEPTH));
        chk({tag, ":overflow"}, 8'(overflow), 8'(m_ovf));
        if (m_count != 0) chk({tag, ":rd_data"}, 8'(rd_data), 8'(sb_q[0]));
        else              chk({tag, ":rd_data0"}, 8'(rd_data), 8'h00);
        do_push = wr_valid && (m_count != DEPTH);
        do_pop  = rd_ready && (m_count != 0);
        if (wr_valid && m_count == DEPTH) m_ovf = 1'b1;
        if (flush) begin
            sb_q.delete();
        end else begin
            if (do_pop)  void'(sb_q.pop_front());
            if (do_push) sb_q.push_back(wr_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ":count"}, 8'(count), 8'h00);
        chk({tag, ":rd_valid"}, 8'(rd_valid), 8'h00);
        chk({tag, ":wr_ready"}, 8'(wr_ready), 8'h01);
        chk({tag, ":overflow"}, 8'(overflow), 8'h00);
        chk({tag, ":rd_data"}, 8'(rd_data), 8'h00);
    endtask

    task automatic fill_to(input int n, input string tag);
        rd_ready = 1'b0;
        while (sb_q.size() < n) begin
            wr_valid = 1'b1;
            wr_data  = nibble_t'($urandom_range(0, 15));
            tick(tag);
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        m_ovf    = 1'b0;
        reset_n  = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 4'h5;
        rd_ready = 1'b0;
        #3;
        chk_reset_vals("reset_held");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset_held_clocked");
        wr_valid = 1'b0;
        reset_n  = 1'b1;

        // First push after reset appears one edge later.
        wr_valid = 1'b1; wr_data = 4'hA;
        tick("first_push");
        wr_valid = 1'b0;
        chk("first_rd_data", 8'(rd_data), 8'h0A);
        chk("first_count", 8'(count), 8'h01);
        rd_ready = 1'b1;
        tick("first_pop");
        rd_ready = 1'b0;

        // Fill 1..8, attempt a ninth write, then drain.
        for (int i = 1; i <= 8; i++) begin
            wr_valid = 1'b1; wr_data = nibble_t'(i);
            tick("fill");
        end
        chk("full_count", 8'(count), 8'h08);
        wr_data = 4'hF;
        tick("ninth_write");
        wr_valid = 1'b0;
        chk("ovf_set", 8'(overflow), 8'h01);
        chk("ovf_count", 8'(count), 8'h08);
        rd_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", 8'(rd_data), 8'(i));
            tick("drain");
        end
        rd_ready = 1'b0;
        tick("drained");

        // Steady stream at count 3 wraps the pointers several times.
        fill_to(3, "pre_stream");
        wr_valid = 1'b1; rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = nibble_t'(i);
            tick("stream");
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
        chk("stream_count", 8'(count), 8'h03);

        // Full with both sides asserted: only the pop happens.
        fill_to(8, "refill");
        wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 4'h7;
        tick("full_both");
        wr_valid = 1'b0; rd_ready = 1'b0;
        chk("full_both_count", 8'(count), 8'h07);
        rd_ready = 1'b1;
        while (sb_q.size() != 0) tick("drain2");
        // Empty with both sides asserted: only the push happens.
        wr_valid = 1'b1; wr_data = 4'hC;
        tick("empty_both");
        wr_valid = 1'b0; rd_ready = 1'b0;
        chk("empty_both_count", 8'(count), 8'h01);
        chk("empty_both_data", 8'(rd_data), 8'h0C);

        // Flush at count 5 beats a simultaneous push and pop.
        fill_to(5, "pre_flush");
        flush = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 4'h9;
        tick("flush");
        flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        chk("flush_count", 8'(count), 8'h00);
        chk("flush_rd_valid", 8'(rd_valid), 8'h00);
        chk("flush_rd_data", 8'(rd_data), 8'h00);
        chk("flush_keeps_ovf", 8'(overflow), 8'h01);
        tick("post_flush");

        // Asynchronous reset between edges mid-stream.
        fill_to(4, "pre_reset");
        wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 4'h2;
        tick("pre_reset_stream");
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        sb_q.delete();
        m_ovf = 1'b0;
        wr_valid = 1'b0; rd_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr_valid = 1'b1; wr_data = 4'h3;
        tick("post_reset_push");
        wr_valid = 1'b0;
        chk("post_reset_data", 8'(rd_data), 8'h03);
        tick("post_reset_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
